dual_port_mem_pipe: RTL and testbench

//  Parametrised dual-ported memory for the Verilator co-simulated core: real storage behind an

---
 rtl/dpmem_pkg.sv | 69 ++++++
 rtl/dual_port_mem_pipe_if.sv | 37 +++
 rtl/dpmem_rd_pipe.sv | 39 +++
 rtl/dual_port_mem_pipe.sv | 97 +++++++++
 tb/tb_dual_port_mem_pipe.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dpmem_pkg.sv
// Shared types and lane/extension helpers for the dual-ported pipelined memory.
// Used by the interface, the read pipeline and the top.
package dpmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MASK_BYTE = 2'b00,
    MASK_HALF = 2'b01,
    MASK_WORD = 2'b10
  } maskmode_e;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] data;
    logic              err;
  } read_rsp_t;

  // Byte offset actually used for the access; unused low bits are dropped.
  function automatic logic [1:0] align_off(input logic [1:0] mode, input logic [1:0] off);
    case (mode)
      MASK_BYTE: align_off = off;
      MASK_HALF: align_off = {off[1], 1'b0};
      default:   align_off = 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] off);
    case (mode)
      MASK_BYTE: misaligned = 1'b0;
      MASK_HALF: misaligned = off[0];
      default:   misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] mode, input logic [1:0] off);
    case (mode)
      MASK_BYTE: lane_en = 4'b0001 << off;
      MASK_HALF: lane_en = off[1] ? 4'b1100 : 4'b0011;
      default:   lane_en = 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data so every enabled lane sees its byte.
  function automatic logic [WORD_W-1:0] place_wdata(input logic [1:0] mode,
                                                    input logic [WORD_W-1:0] wd);
    case (mode)
      MASK_BYTE: place_wdata = {4{wd[7:0]}};
      MASK_HALF: place_wdata = {2{wd[15:0]}};
      default:   place_wdata = wd;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] load_extend(input logic [1:0] mode,
                                                    input logic [1:0] off,
                                                    input logic sext,
                                                    input logic [WORD_W-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (mode)
      MASK_BYTE: load_extend = {{24{sext & b[7]}}, b};
      MASK_HALF: load_extend = {{16{sext & h[15]}}, h};
      default:   load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dual_port_mem_pipe_if.sv
// Fetch and load/store bus of the dual-ported memory; master is the core side.
interface dual_port_mem_pipe_if
  import dpmem_pkg::*;
#(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_address;
   logic              imem_valid;
   logic [WORD_W-1:0] imem_instruction;

   logic [ADDR_W-1:0] dmem_address;
   logic [WORD_W-1:0] dmem_writedata;
   logic              dmem_memread;
   logic              dmem_memwrite;
   logic [1:0]        dmem_maskmode;
   logic              dmem_sext;
   logic              dmem_valid;
   logic [WORD_W-1:0] dmem_readdata;
   logic              dmem_err;

   modport master (
      output imem_req, imem_address,
      output dmem_address, dmem_writedata, dmem_memread, dmem_memwrite,
      output dmem_maskmode, dmem_sext,
      input  imem_valid, imem_instruction,
      input  dmem_valid, dmem_readdata, dmem_err
   );

   modport slave (
      input  imem_req, imem_address,
      input  dmem_address, dmem_writedata, dmem_memread, dmem_memwrite,
      input  dmem_maskmode, dmem_sext,
      output imem_valid, imem_instruction,
      output dmem_valid, dmem_readdata, dmem_err
   );
endinterface

// File: rtl/dpmem_rd_pipe.sv
// Read-response delay line of READ_LAT stages; data holds its last value when not valid.
module dpmem_rd_pipe
  import dpmem_pkg::*;
#(
   parameter int  READ_LAT = 1,
   parameter type rsp_t    = read_rsp_t
) (
   input  logic clk,
   input  logic rst_n,
   input  rsp_t in_rsp,
   output rsp_t out_rsp
);

   for (genvar g = 0; g < READ_LAT; g++) begin : g_stage
      rsp_t prev;
      rsp_t q;

      if (g == 0) begin : g_head
         assign prev = in_rsp;
      end else begin : g_tail
         assign prev = g_stage[g-1].q;
      end

      // NOTE: non-blocking so each stage captures its predecessor's pre-edge value.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else if (prev.valid) begin
            q <= prev;
         end else begin
            q.valid <= 1'b0;
            q.err   <= prev.err;
         end
      end
   end

   assign out_rsp = g_stage[READ_LAT-1].q;

endmodule

// File: rtl/dual_port_mem_pipe.sv
// Dual-ported word memory: instruction read port plus masked data read/write port.
// Define DPMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module dual_port_mem_pipe
  import dpmem_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DEPTH     = 4096,
   parameter int                READ_LAT  = 1,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic                 clk,
   input logic                 rst_n,
   dual_port_mem_pipe_if.slave bus
);

   localparam int         IDX_W  = $clog2(DEPTH);
   localparam logic [63:0] BASE64 = 64'(BASE_ADDR);
   localparam logic [63:0] SPAN64 = 64'(DEPTH) << 2;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (64'(a) >= BASE64) && ((64'(a) - BASE64) < SPAN64);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((64'(a) - BASE64) >> 2);
   endfunction

   logic [WORD_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  i_idx, d_idx;
   logic              i_ok, d_ok;
   logic [1:0]        d_off;
   logic [3:0]        d_lanes;
   logic [WORD_W-1:0] d_wdata;
   read_rsp_t         i_rsp, d_rsp, i_out, d_out;
   logic              unused_imem_err;

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      i_idx   = word_idx(bus.imem_address);
      d_idx   = word_idx(bus.dmem_address);
      d_off   = align_off(bus.dmem_maskmode, bus.dmem_address[1:0]);
      d_lanes = lane_en(bus.dmem_maskmode, d_off);
      d_wdata = place_wdata(bus.dmem_maskmode, bus.dmem_writedata);
`ifdef DPMEM_MISALIGN_TRAP_EN
      i_ok = in_range(bus.imem_address) && (bus.imem_address[1:0] == 2'b00);
      d_ok = in_range(bus.dmem_address) &&
             !misaligned(bus.dmem_maskmode, bus.dmem_address[1:0]);
`else
      i_ok = in_range(bus.imem_address);
      d_ok = in_range(bus.dmem_address);
`endif

      i_rsp       = '0;
      i_rsp.valid = bus.imem_req;
      if (bus.imem_req && i_ok) i_rsp.data = mem[i_idx];

      d_rsp       = '0;
      d_rsp.valid = bus.dmem_memread;
      d_rsp.err   = (bus.dmem_memread || bus.dmem_memwrite) && !d_ok;
      if (bus.dmem_memread && d_ok)
         d_rsp.data = load_extend(bus.dmem_maskmode, d_off, bus.dmem_sext, mem[d_idx]);
   end

   // NOTE: storage is deliberately left out of reset; only the response pipeline clears.
   always_ff @(posedge clk) begin
      if (bus.dmem_memwrite && d_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (d_lanes[b]) mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
         end
      end
   end

   // Reads above sample the array before this edge's write lands, giving old-data collisions.
   dpmem_rd_pipe #(.READ_LAT(READ_LAT), .rsp_t(read_rsp_t)) u_ipipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_rsp (i_rsp),
      .out_rsp(i_out)
   );

   dpmem_rd_pipe #(.READ_LAT(READ_LAT), .rsp_t(read_rsp_t)) u_dpipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_rsp (d_rsp),
      .out_rsp(d_out)
   );

   assign bus.imem_valid       = i_out.valid;
   assign bus.imem_instruction = i_out.data;
   assign unused_imem_err      = i_out.err;

   assign bus.dmem_valid    = d_out.valid;
   assign bus.dmem_readdata = d_out.data;
   assign bus.dmem_err      = d_out.err;

endmodule

// File: tb/tb_dual_port_mem_pipe.sv
// Bench for dual_port_mem_pipe: READ_LAT=1 and READ_LAT=3 instances, queue scoreboards.
// Honours DPMEM_MISALIGN_TRAP_EN for the misaligned half-load expectation.
module tb_dual_port_mem_pipe;
   import dpmem_pkg::*;

   localparam int LAT1  = 1;
   localparam int LAT3  = 3;
   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          due;
   } entry_t;

   logic clk = 1'b0;
   logic rst_n, rst3_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   entry_t iq1[$], dq1[$], iq3[$], dq3[$];
   entry_t e_i1, e_d1, e_i3, e_d3;

   dual_port_mem_pipe_if #(.ADDR_W(32)) bus1 ();
   dual_port_mem_pipe_if #(.ADDR_W(32)) bus3 ();

   dual_port_mem_pipe #(.ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(LAT1), .BASE_ADDR(32'h0)) u_dut1 (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus1)
   );

   dual_port_mem_pipe #(.ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(LAT3), .BASE_ADDR(32'h0)) u_dut3 (
      .clk  (clk),
      .rst_n(rst3_n),
      .bus  (bus3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus1.imem_req = 1'b0; bus1.dmem_memread = 1'b0; bus1.dmem_memwrite = 1'b0;
      bus3.imem_req = 1'b0; bus3.dmem_memread = 1'b0; bus3.dmem_memwrite = 1'b0;
   endtask

   task automatic cycle();
      @(negedge clk);
      idle();
   endtask

   task automatic store(input bit p3, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] mm);
      if (p3) begin
         bus3.dmem_memwrite = 1'b1; bus3.dmem_address = a;
         bus3.dmem_writedata = d;   bus3.dmem_maskmode = mm;
      end else begin
         bus1.dmem_memwrite = 1'b1; bus1.dmem_address = a;
         bus1.dmem_writedata = d;   bus1.dmem_maskmode = mm;
      end
   endtask

   task automatic load(input bit p3, input logic [31:0] a, input logic [1:0] mm,
                       input logic sx, input logic [31:0] exp, input logic eerr);
      if (p3) begin
         bus3.dmem_memread = 1'b1; bus3.dmem_address = a;
         bus3.dmem_maskmode = mm;  bus3.dmem_sext = sx;
         dq3.push_back('{data: exp, err: eerr, due: cyc + LAT3});
      end else begin
         bus1.dmem_memread = 1'b1; bus1.dmem_address = a;
         bus1.dmem_maskmode = mm;  bus1.dmem_sext = sx;
         dq1.push_back('{data: exp, err: eerr, due: cyc + LAT1});
      end
   endtask

   task automatic fetch(input bit p3, input logic [31:0] a, input logic [31:0] exp);
      if (p3) begin
         bus3.imem_req = 1'b1; bus3.imem_address = a;
         iq3.push_back('{data: exp, err: 1'b0, due: cyc + LAT3});
      end else begin
         bus1.imem_req = 1'b1; bus1.imem_address = a;
         iq1.push_back('{data: exp, err: 1'b0, due: cyc + LAT1});
      end
   endtask

   // Scoreboard monitors: every valid response must match the oldest expectation on time.
   always @(negedge clk) begin
      if (bus1.imem_valid) begin
         check("i1_unexpected", {31'b0, iq1.size() != 0}, 32'd1);
         if (iq1.size() != 0) begin
            e_i1 = iq1.pop_front();
            check("i1_data", bus1.imem_instruction, e_i1.data);
            check("i1_latency", 32'(cyc), 32'(e_i1.due));
         end
      end
      if (bus1.dmem_valid) begin
         check("d1_unexpected", {31'b0, dq1.size() != 0}, 32'd1);
         if (dq1.size() != 0) begin
            e_d1 = dq1.pop_front();
            check("d1_data", bus1.dmem_readdata, e_d1.data);
            check("d1_err", {31'b0, bus1.dmem_err}, {31'b0, e_d1.err});
            check("d1_latency", 32'(cyc), 32'(e_d1.due));
         end
      end
      if (bus3.imem_valid) begin
         check("i3_unexpected", {31'b0, iq3.size() != 0}, 32'd1);
         if (iq3.size() != 0) begin
            e_i3 = iq3.pop_front();
            check("i3_data", bus3.imem_instruction, e_i3.data);
            check("i3_latency", 32'(cyc), 32'(e_i3.due));
         end
      end
      if (bus3.dmem_valid) begin
         check("d3_unexpected", {31'b0, dq3.size() != 0}, 32'd1);
         if (dq3.size() != 0) begin
            e_d3 = dq3.pop_front();
            check("d3_data", bus3.dmem_readdata, e_d3.data);
            check("d3_err", {31'b0, bus3.dmem_err}, {31'b0, e_d3.err});
            check("d3_latency", 32'(cyc), 32'(e_d3.due));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst3_n = 1'b0;
      bus1.imem_address = '0; bus1.dmem_address = '0; bus1.dmem_writedata = '0;
      bus1.dmem_maskmode = MASK_WORD; bus1.dmem_sext = 1'b0;
      bus3.imem_address = '0; bus3.dmem_address = '0; bus3.dmem_writedata = '0;
      bus3.dmem_maskmode = MASK_WORD; bus3.dmem_sext = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      #1;
      check("rst_i1_valid", {31'b0, bus1.imem_valid}, 32'd0);
      check("rst_d1_valid", {31'b0, bus1.dmem_valid}, 32'd0);
      check("rst_d1_err", {31'b0, bus1.dmem_err}, 32'd0);
      check("rst_i1_data", bus1.imem_instruction, 32'h0);
      check("rst_d1_data", bus1.dmem_readdata, 32'h0);
      check("rst_i3_valid", {31'b0, bus3.imem_valid}, 32'd0);
      check("rst_d3_valid", {31'b0, bus3.dmem_valid}, 32'd0);
      rst_n = 1'b1; rst3_n = 1'b1;
      cycle();

      // Word store then load.
      store(0, 32'h10, 32'hDEADBEEF, MASK_WORD); cycle();
      load(0, 32'h10, MASK_WORD, 1'b0, 32'hDEADBEEF, 1'b0); cycle();

      // Byte store into the top lane, signed/unsigned byte loads, merged word.
      store(0, 32'h13, 32'h00000080, MASK_BYTE); cycle();
      load(0, 32'h13, MASK_BYTE, 1'b1, 32'hFFFFFF80, 1'b0); cycle();
      load(0, 32'h13, MASK_BYTE, 1'b0, 32'h00000080, 1'b0); cycle();
      load(0, 32'h10, MASK_WORD, 1'b0, 32'h80ADBEEF, 1'b0); cycle();

      // Upper half store, signed half load, merged word, positive signed byte.
      store(0, 32'h14, 32'h12345678, MASK_WORD); cycle();
      store(0, 32'h16, 32'h0000A5C3, MASK_HALF); cycle();
      load(0, 32'h16, MASK_HALF, 1'b1, 32'hFFFFA5C3, 1'b0); cycle();
      load(0, 32'h14, MASK_WORD, 1'b0, 32'hA5C35678, 1'b0); cycle();
      load(0, 32'h15, MASK_BYTE, 1'b1, 32'h00000056, 1'b0); cycle();

      // Load and store together: load sees pre-store data, next load sees new data.
      store(0, 32'h18, 32'h0BADF00D, MASK_WORD); cycle();
      store(0, 32'h18, 32'hCAFEF00D, MASK_WORD);
      load(0, 32'h18, MASK_WORD, 1'b0, 32'h0BADF00D, 1'b0); cycle();
      load(0, 32'h18, MASK_WORD, 1'b0, 32'hCAFEF00D, 1'b0); cycle();
      cycle();
      #1;
      check("d1_hold_valid", {31'b0, bus1.dmem_valid}, 32'd0);
      check("d1_hold_data", bus1.dmem_readdata, 32'hCAFEF00D);

      // Range edges: last word works, one past the end errors and never aliases word 0.
      store(0, 32'h00, 32'h01020304, MASK_WORD); cycle();
      store(0, 32'h3C, 32'h55AA55AA, MASK_WORD); cycle();
      load(0, 32'h3C, MASK_WORD, 1'b0, 32'h55AA55AA, 1'b0); cycle();
      load(0, 32'h40, MASK_WORD, 1'b0, 32'h00000000, 1'b1); cycle();
      store(0, 32'h40, 32'hFFFFFFFF, MASK_WORD); cycle();
      load(0, 32'h00, MASK_WORD, 1'b0, 32'h01020304, 1'b0); cycle();
      fetch(0, 32'h10, 32'h80ADBEEF); cycle();
      fetch(0, 32'h40, 32'h00000000); cycle();
`ifdef DPMEM_MISALIGN_TRAP_EN
      load(0, 32'h11, MASK_HALF, 1'b0, 32'h00000000, 1'b1); cycle();
`else
      load(0, 32'h11, MASK_HALF, 1'b0, 32'h0000BEEF, 1'b0); cycle();
`endif
      repeat (2) cycle();

      // READ_LAT=3: preload, then three back-to-back fetches.
      store(1, 32'h00, 32'hA0000000, MASK_WORD); cycle();
      store(1, 32'h04, 32'hA0000004, MASK_WORD); cycle();
      store(1, 32'h08, 32'hA0000008, MASK_WORD); cycle();
      store(1, 32'h20, 32'h11111111, MASK_WORD); cycle();
      fetch(1, 32'h00, 32'hA0000000); cycle();
      fetch(1, 32'h04, 32'hA0000004); cycle();
      fetch(1, 32'h08, 32'hA0000008); cycle();
      repeat (3) cycle();
      #1;
      check("i3_hold_valid", {31'b0, bus3.imem_valid}, 32'd0);
      check("i3_hold_data", bus3.imem_instruction, 32'hA0000008);

      // Port collision: fetch returns old word, next fetch returns the stored word.
      fetch(1, 32'h20, 32'h11111111);
      store(1, 32'h20, 32'h22222222, MASK_WORD); cycle();
      fetch(1, 32'h20, 32'h22222222); cycle();
      fetch(1, 32'h40, 32'h00000000); cycle();
      load(1, 32'h20, MASK_WORD, 1'b0, 32'h22222222, 1'b0); cycle();
      repeat (4) cycle();

      // Reset with reads in flight drops them all.
      fetch(1, 32'h00, 32'hA0000000);
      load(1, 32'h04, MASK_WORD, 1'b0, 32'hA0000004, 1'b0); cycle();
      fetch(1, 32'h08, 32'hA0000008); cycle();
      #2;
      rst3_n = 1'b0;
      iq3.delete();
      dq3.delete();
      #1;
      check("rst_mid_i3_valid", {31'b0, bus3.imem_valid}, 32'd0);
      check("rst_mid_d3_valid", {31'b0, bus3.dmem_valid}, 32'd0);
      check("rst_mid_i3_data", bus3.imem_instruction, 32'h0);
      check("rst_mid_d3_data", bus3.dmem_readdata, 32'h0);
      repeat (2) @(negedge clk);
      rst3_n = 1'b1;
      repeat (6) cycle();
      #1;
      check("post_rst_i3_data", bus3.imem_instruction, 32'h0);
      check("post_rst_d3_data", bus3.dmem_readdata, 32'h0);

      check("drain_i1", 32'(iq1.size()), 32'd0);
      check("drain_d1", 32'(dq1.size()), 32'd0);
      check("drain_i3", 32'(iq3.size()), 32'd0);
      check("drain_d3", 32'(dq3.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
